ahb_req_arb: RTL
================

// Module: ahb_req_arb
// PURPOSE
//  Shares the single AHB master request port (req/wr/start_addr/byte_cnt,
//  req_ack) between NREQ client engines. Uses round-robin arbitration.
//  Latches the winning client's descriptor and presents it to the master.
//  Tracks the burst until the master reports completion, then re-arbitrates.
//  Sits between DMA-style clients and ahb_m; the master's pin side is untouched.
// PARAMETERS
//  NREQ       4   number of requesting clients (2..8)
//  ADDRW      32  start address width
//  BYTE_CNTW  16  transfer byte-count width
//  IDW        $clog2(NREQ)  grant index width (derived, not overridable)
// PORTS
//  clk           in   1              system clock, rising edge
//  rst           in   1              async active-low reset
//  req_i         in   NREQ           per-client request; held until its ack_o
//  wr_i          in   NREQ           per-client direction: 1 write, 0 read
//  addr_i        in   NREQ*ADDRW     per-client start address; slice k = client k
//  byte_cnt_i    in   NREQ*BYTE_CNTW per-client byte count; slice k = client k
//  ack_o         out  NREQ           1-cycle pulse: client descriptor accepted
//  done_o        out  NREQ           1-cycle pulse: client transfer complete
//  m_req         out  1              request to ahb_m
//  m_wr          out  1              direction to ahb_m
//  m_start_addr  out  ADDRW          start address to ahb_m
//  m_byte_cnt    out  BYTE_CNTW      byte count to ahb_m
//  m_req_ack     in   1              ahb_m accepted descriptor (1-cycle pulse)
//  m_done        in   1              ahb_m finished the burst (1-cycle pulse)
//  busy          out  1              high in any state other than IDLE
//  grant_id      out  IDW            index of the current or last granted client
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (rst=0, async) forces all outputs to 0.
//  - Reset also sets state=IDLE and the round-robin pointer ptr=0.
//  - FSM states: IDLE, ISSUE, WAIT_DONE.
//  - IDLE, one or more req_i set: winner = first set bit scanning ptr, ptr+1, ...
//    mod NREQ. Latch the winner's wr/addr/byte_cnt and set grant_id=winner.
//  - IDLE, winner byte_cnt != 0: next cycle m_req=1; go to ISSUE.
//    The edge that samples req_i is followed by m_req high, i.e. 1 cycle latency.
//  - IDLE, winner byte_cnt == 0: never forwarded to the master.
//    Pulse ack_o[w] and done_o[w] together next cycle; ptr=w+1; stay in IDLE.
//    The next arbitration happens the cycle after those pulses.
//  - ISSUE: m_req and all m_* fields stay constant until m_req_ack is sampled 1.
//    There is no timeout.
//  - ISSUE, m_req_ack=1: next cycle m_req=0 and ack_o[w]=1 for exactly 1 cycle.
//    Go to WAIT_DONE.
//  - ISSUE, m_req_ack=1 and m_done=1 in the same cycle: pulse ack_o[w] and
//    done_o[w] together; ptr=w+1; go to IDLE.
//  - WAIT_DONE, m_done=1: next cycle done_o[w]=1 for 1 cycle; ptr=w+1; go to IDLE.
//    No new grant is issued in the cycle that done_o pulses.
//  - m_req_ack or m_done arriving in a state that does not expect it is ignored.
//    No outputs change.
//  - Once latched, a client dropping req_i before its ack_o does not abort the
//    transfer. The block still pulses ack_o and done_o for that client.
//  - New req_i edges and descriptor changes are ignored outside IDLE.
//    The latched copy is authoritative.
//  - Fairness: a client that just completed has the lowest priority next round.
//    With all clients requesting continuously, the grant order is
//    0,1,..,NREQ-1,0.
//  - ptr arithmetic wraps modulo NREQ; NREQ need not be a power of two.
//  - busy = (state != IDLE).
//  - grant_id holds its value after the transfer completes, until the next grant.
//  - Reset asserted mid-transfer: m_req drops immediately and the latched
//    descriptor is discarded.
//    After reset no ack_o or done_o pulse is produced for the aborted client.
// TESTING
//  1. Client0 only: wr=1, addr=0x40, cnt=384; ack after 3 cycles -> m_* match.
//     ack_o[0] pulses once; done_o[0] pulses once after m_done.
//  2. Clients 1 and 2 raise req_i in the same cycle with ptr=0.
//     -> client1 granted first, then client2; grant_id sequence 1,2.
//  3. All 4 clients request continuously for 8 transfers.
//     -> grant_id sequence 0,1,2,3,0,1,2,3; each client gets exactly 2 ack/done.
//  4. Client3 with cnt=0 -> m_req stays 0; ack_o[3] and done_o[3] pulse in the
//     same cycle; ptr advances to 0.
//  5. m_req_ack held low for 10 random cycles -> m_req and all fields stable.
//     Then drive m_req_ack and m_done in the same cycle -> both pulses together;
//     state returns to IDLE.
//  6. Reset in WAIT_DONE with client2 granted -> all outputs 0 asynchronously.
//     After reset: no done_o[2]; next grant scans from client0.

Source files
------------

// File: rtl/ahb_req_arb.sv
// Round-robin arbiter that shares one AHB master request port between NREQ
// clients, latching the winning descriptor and tracking the burst to completion.
module ahb_req_arb #(
  parameter int NREQ      = 4,
  parameter int ADDRW     = 32,
  parameter int BYTE_CNTW = 16,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           wr_i,
  input  logic [NREQ*ADDRW-1:0]     addr_i,
  input  logic [NREQ*BYTE_CNTW-1:0] byte_cnt_i,
  output logic [NREQ-1:0]           ack_o,
  output logic [NREQ-1:0]           done_o,
  output logic                      m_req,
  output logic                      m_wr,
  output logic [ADDRW-1:0]          m_start_addr,
  output logic [BYTE_CNTW-1:0]      m_byte_cnt,
  input  logic                      m_req_ack,
  input  logic                      m_done,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t               state, state_nx;
  logic [IDW-1:0]       ptr, ptr_nx;
  logic [IDW:0]         pick;
  logic [IDW-1:0]       win;
  logic                 m_req_nx, m_wr_nx, busy_nx;
  logic [ADDRW-1:0]     addr_nx;
  logic [BYTE_CNTW-1:0] cnt_nx;
  logic [IDW-1:0]       grant_nx;
  logic [NREQ-1:0]      ack_nx, done_nx;

  // Returns {found, index}: first requester at or after start, wrapping mod NREQ.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [IDW-1:0]  start);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NREQ;
      if (req[IDW'(idx)]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    m_req_nx = m_req;
    m_wr_nx  = m_wr;
    addr_nx  = m_start_addr;
    cnt_nx   = m_byte_cnt;
    grant_nx = grant_id;
    ack_nx   = '0;
    done_nx  = '0;
    pick     = rr_pick(req_i, ptr);
    win      = pick[IDW-1:0];
    case (state)
      IDLE: begin
        // A completion pulse in flight blocks arbitration for that one cycle.
        if (pick[IDW] && (done_o == '0)) begin
          grant_nx = win;
          m_wr_nx  = wr_i[win];
          addr_nx  = addr_i[int'(win)*ADDRW +: ADDRW];
          cnt_nx   = byte_cnt_i[int'(win)*BYTE_CNTW +: BYTE_CNTW];
          if (cnt_nx != '0) begin
            m_req_nx = 1'b1;
            state_nx = ISSUE;
          end else begin
            ack_nx[win]  = 1'b1;
            done_nx[win] = 1'b1;
            ptr_nx       = wrap_inc(win);
          end
        end
      end
      ISSUE: begin
        if (m_req_ack) begin
          m_req_nx         = 1'b0;
          ack_nx[grant_id] = 1'b1;
          if (m_done) begin
            done_nx[grant_id] = 1'b1;
            ptr_nx            = wrap_inc(grant_id);
            state_nx          = IDLE;
          end else begin
            state_nx = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (m_done) begin
          done_nx[grant_id] = 1'b1;
          ptr_nx            = wrap_inc(grant_id);
          state_nx          = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      m_req        <= 1'b0;
      m_wr         <= 1'b0;
      m_start_addr <= '0;
      m_byte_cnt   <= '0;
      grant_id     <= '0;
      ack_o        <= '0;
      done_o       <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      m_req        <= m_req_nx;
      m_wr         <= m_wr_nx;
      m_start_addr <= addr_nx;
      m_byte_cnt   <= cnt_nx;
      grant_id     <= grant_nx;
      ack_o        <= ack_nx;
      done_o       <= done_nx;
      busy         <= busy_nx;
    end
  end

endmodule
